// File: rtl/addsub_pkg.sv
// addsub_pkg
//   Shared definitions for the digit-serial add/subtract engine:
//   - state_t     : engine FSM states (IDLE / RUN / DONE)
//   - MODE_ADD/SUB: meaning of the in_mode input
//   - num_slices(): number of CHUNK-wide slices per G-bit operand
//   - idx_width() : width of the slice index register (at least 1 bit)
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of slices needed to cover a G-bit operand.
  function automatic int num_slices(input int g, input int chunk);
    return g / chunk;
  endfunction

  // Width of the slice index; a single-slice engine still gets a 1-bit index.
  function automatic int idx_width(input int g, input int chunk);
    int n;
    n = g / chunk;
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice
//   Combinational W-bit ripple chain of full adders. This is the only
//   arithmetic in the engine; the top level reuses it once per slice.
// Ports:
//   a, b      in  W : slice operands (b already inverted for subtract)
//   cin       in  1 : carry into bit 0 of the slice
//   sum       out W : slice sum
//   cout      out 1 : carry out of the top bit
//   c_msb_in  out 1 : carry into the top bit (needed for signed overflow)
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c_s;

  // Ripple the carry from bit 0 upward, one full adder per bit.
  always_comb begin
    c_s    = '0;
    sum    = '0;
    c_s[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c_s[W];
  assign c_msb_in = c_s[W-1];

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial
//   Digit-serial G-bit add/subtract engine. One operand pair is accepted in
//   IDLE, then CHUNK bits are summed per clock through a single addsub_slice
//   with the carry held in a register between cycles. After N = G/CHUNK RUN
//   cycles the result is presented in DONE and held until the consumer takes
//   it.
// Ports:
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   in_valid/ready   : operand handshake (in_ready is high only in IDLE)
//   in_a, in_b       : G-bit operands
//   in_mode          : MODE_ADD uses B as-is, MODE_SUB uses ~B
//   in_cin           : carry into bit 0 (1 with MODE_SUB gives A-B)
//   out_valid/ready  : result handshake (out_valid is high only in DONE)
//   out_sum          : G-bit result
//   out_carry        : carry out of bit G-1
//   out_ovf          : signed overflow (carry into MSB xor carry out of MSB)
//   busy             : high in RUN or DONE
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int G     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [G-1:0] in_a,
  input  logic [G-1:0] in_b,
  input  logic         in_mode,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [G-1:0] out_sum,
  output logic         out_carry,
  output logic         out_ovf,
  output logic         busy
);

  localparam int              N        = num_slices(G, CHUNK);
  localparam int              IW       = idx_width(G, CHUNK);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [G-1:0]      a_r;
  logic [G-1:0]      b_r;       // effective B: already inverted for subtract
  logic              carry_r;
  logic [IW-1:0]     idx_r;

  int                base_s;
  logic [CHUNK-1:0]  a_sl_s;
  logic [CHUNK-1:0]  b_sl_s;
  logic [CHUNK-1:0]  sum_sl_s;
  logic              cout_s;
  logic              cmsb_s;
  logic              last_s;

  // Select the operand slice addressed by the current index.
  always_comb begin
    base_s = int'(idx_r) * CHUNK;
    a_sl_s = a_r[base_s +: CHUNK];
    b_sl_s = b_r[base_s +: CHUNK];
    last_s = (idx_r == LAST_IDX);
  end

  addsub_slice #(
    .W (CHUNK)
  ) u_slice (
    .a        (a_sl_s),
    .b        (b_sl_s),
    .cin      (carry_r),
    .sum      (sum_sl_s),
    .cout     (cout_s),
    .c_msb_in (cmsb_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Operand capture, slice-by-slice accumulation and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      idx_r     <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_r     <= (in_mode == MODE_SUB) ? ~in_b : in_b;
            carry_r <= in_cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          out_sum[base_s +: CHUNK] <= sum_sl_s;
          carry_r                  <= cout_s;
          if (last_s) begin
            // Top slice: its carry-out and carry-into-MSB are the word's.
            idx_r     <= '0;
            out_carry <= cout_s;
            out_ovf   <= cout_s ^ cmsb_s;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          // Result held until the consumer accepts it.
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial
//   Drives three engines (CHUNK = 1, 8, 32 with G = 32) in lockstep with the
//   same operands. Expected results are queued when an operation is launched
//   and popped when the engines present their outputs.
module tb_addsub_serial;
  import addsub_pkg::*;

  localparam int G = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [G-1:0] in_a = '0;
  logic [G-1:0] in_b = '0;
  logic         in_mode = 1'b0;
  logic         in_cin = 1'b0;
  logic         out_ready = 1'b0;

  logic [2:0]        in_ready_w;
  logic [2:0]        out_valid_w;
  logic [2:0]        out_carry_w;
  logic [2:0]        out_ovf_w;
  logic [2:0]        busy_w;
  logic [2:0][G-1:0] out_sum_w;

  typedef struct packed {
    logic [G-1:0] sum;
    logic         carry;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_lat [3] = '{32, 4, 1};

  always #5 clk = ~clk;

  addsub_serial #(.G(G), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_cin(in_cin),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_sum(out_sum_w[0]),
    .out_carry(out_carry_w[0]), .out_ovf(out_ovf_w[0]), .busy(busy_w[0])
  );

  addsub_serial #(.G(G), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_cin(in_cin),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_sum(out_sum_w[1]),
    .out_carry(out_carry_w[1]), .out_ovf(out_ovf_w[1]), .busy(busy_w[1])
  );

  addsub_serial #(.G(G), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_cin(in_cin),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_sum(out_sum_w[2]),
    .out_carry(out_carry_w[2]), .out_ovf(out_ovf_w[2]), .busy(busy_w[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width modulo-2^G arithmetic; overflow from operand signs.
  function automatic exp_t model(input logic [G-1:0] a, input logic [G-1:0] b,
                                 input logic mode, input logic cin);
    exp_t         m;
    logic [G-1:0] be;
    logic [G:0]   full;
    be      = (mode == MODE_SUB) ? ~b : b;
    full    = {1'b0, a} + {1'b0, be} + {{G{1'b0}}, cin};
    m.sum   = full[G-1:0];
    m.carry = full[G];
    m.ovf   = (a[G-1] == be[G-1]) && (m.sum[G-1] != a[G-1]);
    return m;
  endfunction

  task automatic launch(input logic [G-1:0] a, input logic [G-1:0] b,
                        input logic mode, input logic cin, input exp_t e);
    check("in_ready_idle", 64'(in_ready_w), 64'(3'b111));
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_cin   = cin;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int lat [3];
    int cyc;
    lat = '{0, 0, 0};
    cyc = 0;
    while (!(lat[0] != 0 && lat[1] != 0 && lat[2] != 0) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (lat[k] == 0 && out_valid_w[k]) lat[k] = cyc;
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("latency_c%0d", k), 64'(lat[k]), 64'(exp_lat[k]));
    end
  endtask

  task automatic check_result();
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'(0), 64'(1));
    end else begin
      cur = sb_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("sum_c%0d", k),   64'(out_sum_w[k]),   64'(cur.sum));
        check($sformatf("carry_c%0d", k), 64'(out_carry_w[k]), 64'(cur.carry));
        check($sformatf("ovf_c%0d", k),   64'(out_ovf_w[k]),   64'(cur.ovf));
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after", 64'(in_ready_w), 64'(3'b111));
    check("out_valid_after", 64'(out_valid_w), 64'(3'b000));
  endtask

  task automatic do_op(input logic [G-1:0] a, input logic [G-1:0] b,
                       input logic mode, input logic cin, input exp_t e);
    launch(a, b, mode, cin, e);
    wait_done();
    check_result();
    release_out();
  endtask

  function automatic exp_t mk(input logic [G-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum   = s;
    e.carry = c;
    e.ovf   = o;
    return e;
  endfunction

  initial begin
    logic [G-1:0] ra;
    logic [G-1:0] rb;
    logic         rm;
    logic         rc;
    logic [G-1:0] corner [4];
    corner = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready_w), 64'(3'b111));
    check("rst_out_valid", 64'(out_valid_w), 64'(3'b000));
    check("rst_busy", 64'(busy_w), 64'(3'b000));
    check("rst_sum", 64'(out_sum_w), 64'(0));
    check("rst_carry", 64'(out_carry_w), 64'(3'b000));
    check("rst_ovf", 64'(out_ovf_w), 64'(3'b000));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic with hand-derived results.
    do_op(32'h0000_00FF, 32'h0000_0001, MODE_ADD, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0));
    do_op(32'd5, 32'd7, MODE_SUB, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
    do_op(32'd7, 32'd5, MODE_SUB, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0));
    do_op(32'h7FFF_FFFF, 32'h0000_0001, MODE_ADD, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
    do_op(32'hFFFF_FFFF, 32'h0000_0001, MODE_ADD, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
    do_op(32'h8000_0000, 32'h8000_0000, MODE_ADD, 1'b0, mk(32'h0000_0000, 1'b1, 1'b1));

    // Backpressure: result held 10 cycles while new operands are offered.
    launch(32'h1234_5678, 32'h0101_0101, MODE_ADD, 1'b0, mk(32'h1335_5779, 1'b0, 1'b0));
    wait_done();
    check_result();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        in_a     = $urandom;
        in_b     = $urandom;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_sum", 64'(out_sum_w[1]), 64'(cur.sum));
      check("bp_out_valid", 64'(out_valid_w), 64'(3'b111));
      check("bp_in_ready", 64'(in_ready_w), 64'(3'b000));
      check("bp_busy", 64'(busy_w), 64'(3'b111));
    end
    release_out();
    do_op(32'd100, 32'd23, MODE_SUB, 1'b1, mk(32'd77, 1'b1, 1'b0));

    // Asynchronous reset during the second RUN cycle of the CHUNK=8 engine.
    launch(32'hDEAD_BEEF, 32'h0000_1111, MODE_ADD, 1'b0, mk(32'h0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid_w), 64'(3'b000));
    check("ar_busy", 64'(busy_w), 64'(3'b000));
    check("ar_sum", 64'(out_sum_w[1]), 64'(0));
    void'(sb_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ar_in_ready", 64'(in_ready_w), 64'(3'b111));
    do_op(32'd3, 32'd4, MODE_ADD, 1'b0, mk(32'd7, 1'b0, 1'b0));

    // Random sweep, all three chunk widths in lockstep.
    for (int n = 0; n < 1000; n++) begin
      ra = (n % 16 == 0) ? corner[$urandom_range(0, 3)] : G'($urandom);
      rb = (n % 16 == 8) ? corner[$urandom_range(0, 3)] : G'($urandom);
      rm = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      do_op(ra, rb, rm, rc, model(ra, rb, rm, rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
